// File: rtl/cnn_layer_accel_pooler_feeder.sv
// Pooler feeder: issues one 64-bit opcode per job, then streams exactly job_pixels pixels
// from upstream to the pooler through a 2-entry skid buffer. Pixel latency is 1 cycle; 1 pixel/cycle sustained.
// Backpressure: datain_ready low holds the buffer head stable; src_ready drops when the buffer is full or the job's pixels are all fetched.
// Optional build macro POOLER_FEEDER_STATS_EN adds a stall_count output (STREAM cycles spent stalled on datain_ready).
module cnn_layer_accel_pooler_feeder #(
    parameter int C_DATAIN_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               job_pixels,
    input  logic [15:0]               job_width,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [C_DATAIN_WIDTH-1:0] src_data,
    input  logic                      src_valid,
    output logic                      src_ready,
    output logic [63:0]               opcode,
    output logic                      opcode_valid,
    input  logic                      opcode_accept,
    output logic [C_DATAIN_WIDTH-1:0] datain,
    output logic                      datain_valid,
    input  logic                      datain_ready,
    output logic                      busy,
    output logic                      done
`ifdef POOLER_FEEDER_STATS_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPCODE = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    state_q, state_d;

    // Job parameters captured at job accept; they also form the opcode
    logic [31:0]               pixels_q;
    logic [15:0]               width_q;

    // accepted_count counts upstream pushes, sent_count counts pooler pops
    logic [31:0]               acc_q;
    logic [31:0]               sent_q;

    // Two-entry FIFO-ordered skid buffer
    logic [C_DATAIN_WIDTH-1:0] mem_q [2];
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [1:0]                fill_q, fill_d;

    logic                      job_take;
    logic                      push;
    logic                      pop;
    logic                      last_pop;

    assign job_take = (state_q == S_IDLE) && job_valid;
    assign push     = src_valid && src_ready;
    assign pop      = datain_valid && datain_ready;
    assign last_pop = pop && (sent_q == (pixels_q - 32'd1));

    // Registered opcode fields are stable for the whole OPCODE phase
    assign opcode = {16'h0000, width_q, pixels_q};
    assign datain = mem_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero-pixel job skips straight to DONE after the opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    state_d = S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (opcode_accept) begin
                    state_d = (pixels_q == 32'd0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; src_ready uses registered fill so a pop at fill==2 frees a slot only next cycle
    always_comb begin
        job_ready    = (state_q == S_IDLE) && !rst;
        opcode_valid = (state_q == S_OPCODE);
        src_ready    = (state_q == S_STREAM) && (fill_q < 2'd2) && (acc_q < pixels_q);
        datain_valid = (state_q == S_STREAM) && (fill_q != 2'd0);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
    end

    // Buffer occupancy after this cycle's push/pop
    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Job latch, counters and skid buffer; a new job starts from an empty buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            pixels_q <= '0;
            width_q  <= '0;
            acc_q    <= '0;
            sent_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (job_take) begin
            pixels_q <= job_pixels;
            width_q  <= job_width;
            acc_q    <= '0;
            sent_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= src_data;
                wr_ptr_q        <= ~wr_ptr_q;
                acc_q           <= acc_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                sent_q   <= sent_q + 32'd1;
            end
            fill_q <= fill_d;
        end
    end

`ifdef POOLER_FEEDER_STATS_EN
    logic [31:0] stall_q;

    assign stall_count = stall_q;

    // Count cycles the pooler refuses an offered pixel; value holds after done until the next job
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (job_take) begin
            stall_q <= '0;
        end else if ((state_q == S_STREAM) && datain_valid && !datain_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_layer_accel_pooler_feeder.sv
// Directed bench for the pooler feeder: opcode handshake, streaming order, stalls, zero-pixel job,
// over-offering upstream and mid-job reset.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
module tb_cnn_layer_accel_pooler_feeder;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   job_pixels;
    logic [15:0]   job_width;
    logic          job_valid;
    logic          job_ready;
    logic [W-1:0]  src_data;
    logic          src_valid;
    logic          src_ready;
    logic [63:0]   opcode;
    logic          opcode_valid;
    logic          opcode_accept;
    logic [W-1:0]  datain;
    logic          datain_valid;
    logic          datain_ready;
    logic          busy;
    logic          done;
`ifdef POOLER_FEEDER_STATS_EN
    logic [31:0]   stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cnn_layer_accel_pooler_feeder #(.C_DATAIN_WIDTH(W)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .job_pixels    (job_pixels),
        .job_width     (job_width),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .opcode        (opcode),
        .opcode_valid  (opcode_valid),
        .opcode_accept (opcode_accept),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_ready  (datain_ready),
        .busy          (busy),
        .done          (done)
`ifdef POOLER_FEEDER_STATS_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_src_ready"},    src_ready, 0);
        check({tag, "_opcode"},       opcode, 0);
        check({tag, "_opcode_valid"}, opcode_valid, 0);
        check({tag, "_datain"},       datain, 0);
        check({tag, "_datain_valid"}, datain_valid, 0);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_done"},         done, 0);
    endtask

    // One job: acc_dly = cycles opcode_accept is held low, stall_per = datain_ready low every Nth
    // stream cycle (0 = never), offer = pixels upstream is willing to give, abort_at = transfers before rst (0 = none)
    task automatic run_job(input int npix, input int nwidth, input int acc_dly, input int stall_per,
                           input int offer, input int abort_at);
        int          k;
        int          c;
        int          sent;
        int          acc;
        int          fill;
        int          stalls;
        int          first_c;
        int          last_c;
        logic        ok;
        logic        prev_stall;
        logic [W-1:0] prev_dat;
        logic [63:0] exp_op;
        logic [31:0] np;
        logic [15:0] nw;

        np     = npix;
        nw     = nwidth[15:0];
        exp_op = {16'h0000, nw, np};

        @(negedge clk);
        job_pixels = np;
        job_width  = nw;
        job_valid  = 1'b1;
        #1;
        check("job_ready_idle", job_ready, 1);
        check("busy_idle", busy, 0);

        @(negedge clk);
        job_valid  = 1'b0;
        job_pixels = 32'hDEAD_BEEF;
        job_width  = 16'hFFFF;

        k  = 0;
        ok = 1'b0;
        while (!ok && k < 50) begin
            opcode_accept = (k >= acc_dly);
            #1;
            check("opcode_valid", opcode_valid, 1);
            check("opcode", opcode, exp_op);
            check("src_ready_opcode", src_ready, 0);
            check("job_ready_busy", job_ready, 0);
            ok = opcode_accept;
            k++;
            @(negedge clk);
        end
        if (!ok) check("opcode_timeout", 0, 1);
        opcode_accept = 1'b0;
        check("opcode_cycles", k, acc_dly + 1);

        c          = 0;
        sent       = 0;
        acc        = 0;
        stalls     = 0;
        first_c    = 0;
        last_c     = 0;
        prev_stall = 1'b0;
        prev_dat   = '0;
        while (sent < npix && c < 2000) begin
            datain_ready = (stall_per == 0) ? 1'b1 : ((c % stall_per) != (stall_per - 1));
            src_valid    = (acc < offer);
            src_data     = 16'h1000 + acc[15:0];
            #1;
            fill = acc - sent;
            check("src_ready_rule", src_ready, (fill < 2) && (acc < npix));
            check("datain_valid_fill", datain_valid, fill > 0);
            check("opcode_valid_stream", opcode_valid, 0);
            check("done_stream", done, 0);
            if (prev_stall) begin
                check("hold_valid", datain_valid, 1);
                check("hold_data", datain, prev_dat);
            end
            prev_stall = datain_valid && !datain_ready;
            prev_dat   = datain;
            if (datain_valid && !datain_ready) stalls++;
            if (datain_valid && datain_ready) begin
                check("datain_order", datain, 16'h1000 + sent[15:0]);
                if (sent == 0) first_c = c;
                last_c = c;
                sent++;
            end
            if (src_valid && src_ready) acc++;
            c++;
            @(negedge clk);
            if (abort_at > 0 && sent == abort_at) begin
                rst          = 1'b1;
                src_valid    = 1'b0;
                datain_ready = 1'b0;
                #1;
                check("job_ready_in_rst", job_ready, 0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                check("abort_job_ready", job_ready, 1);
                return;
            end
        end
        if (c >= 2000) check("stream_timeout", 0, 1);
        check("sent_total", sent, npix);
        check("acc_total", acc, npix);
        if (stall_per == 0 && npix > 0) check("throughput", last_c - first_c + 1, npix);

        #1;
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("src_ready_done", src_ready, 0);
        check("datain_valid_done", datain_valid, 0);
`ifdef POOLER_FEEDER_STATS_EN
        check("stall_count", stall_count, stalls);
`endif
        @(negedge clk);
        #1;
        check("done_single", done, 0);
        check("busy_after", busy, 0);
        check("job_ready_after", job_ready, 1);
        check("src_ready_after", src_ready, 0);
`ifdef POOLER_FEEDER_STATS_EN
        check("stall_count_hold", stall_count, stalls);
`endif
        src_valid    = 1'b0;
        datain_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        job_pixels    = '0;
        job_width     = '0;
        job_valid     = 1'b0;
        src_data      = '0;
        src_valid     = 1'b0;
        opcode_accept = 1'b0;
        datain_ready  = 1'b0;

        @(negedge clk);
        #1;
        check("job_ready_rst", job_ready, 0);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("job_ready_post_rst", job_ready, 1);

        // 10x10 job, everything ready
        run_job(100, 10, 0, 0, 100, 0);
        // same job, pooler stalls every 3rd cycle
        run_job(100, 10, 0, 3, 100, 0);
        // opcode accept delayed 5 cycles
        run_job(100, 10, 5, 0, 100, 0);
        // zero-pixel job
        run_job(0, 10, 0, 0, 0, 0);
        // upstream over-offers
        run_job(100, 10, 0, 0, 120, 0);
        // reset after 40 transfers, then a fresh job
        run_job(100, 10, 0, 0, 100, 40);
        run_job(100, 10, 0, 0, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
